// File: rtl/rf_pkg.sv
// Shared register-file definitions: address/data widths and the writeback entry layout.
package rf_pkg;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned NUM_REGS   = 16;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_entry_fifo.sv
// In-order writeback entry store: two enqueues (a older than b) and one dequeue per cycle.
module wb_entry_fifo
  import rf_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_a_i,
  input  wb_entry_t       entry_a_i,
  input  logic            push_b_i,
  input  wb_entry_t       entry_b_i,
  input  logic            pop_i,
  output wb_entry_t       entries_o [Depth],
  output logic [PtrW-1:0] head_o,
  output logic [CntW-1:0] count_o
);

  wb_entry_t       mem_q [Depth];
  wb_entry_t       mem_d [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] slot_b;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    // b lands behind a when both arrive together
    slot_b = push_a_i ? tail_q + PtrW'(1) : tail_q;
    if (pop_i) begin
      mem_d[head_q].valid = 1'b0;
      head_d              = head_q + PtrW'(1);
    end
    if (push_a_i) begin
      mem_d[tail_q]       = entry_a_i;
      mem_d[tail_q].valid = 1'b1;
    end
    if (push_b_i) begin
      mem_d[slot_b]       = entry_b_i;
      mem_d[slot_b].valid = 1'b1;
    end
    tail_d  = tail_q + PtrW'(push_a_i) + PtrW'(push_b_i);
    count_d = count_q + CntW'(push_a_i) + CntW'(push_b_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign entries_o = mem_q;
  assign head_o    = head_q;
  assign count_o   = count_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Buffers ALU and load results in order, retires one register write per cycle,
// and offers decode-side bypass plus a pending-register mask.
module reg_writeback_queue
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                wb_hold,
  output logic [ADDR_W-1:0]   rf_rd,
  output logic [DATA_W-1:0]   rf_data,
  output logic                rf_wr,
  input  logic [ADDR_W-1:0]   q_rs,
  input  logic [ADDR_W-1:0]   q_rt,
  output logic                rs_hit,
  output logic [DATA_W-1:0]   rs_data,
  output logic                rt_hit,
  output logic [DATA_W-1:0]   rt_data,
  output logic [NUM_REGS-1:0] pending,
  output logic [CntW-1:0]     count
);

  wb_entry_t       entries [DEPTH];
  wb_entry_t       mem_entry, alu_entry, head_entry;
  logic [PtrW-1:0] head;
  logic            mem_push, alu_push;

  // Readiness looks only at registered occupancy; a same-cycle retire gives no credit.
  assign mem_ready = (count <= CntW'(DEPTH - 1));
  assign alu_ready = (count <= CntW'(DEPTH - 2)) || ((count == CntW'(DEPTH - 1)) && !mem_valid);
  assign mem_push  = mem_valid & mem_ready;
  assign alu_push  = alu_valid & alu_ready;

  assign mem_entry = '{valid: 1'b1, rd: mem_rd, data: mem_data};
  assign alu_entry = '{valid: 1'b1, rd: alu_rd, data: alu_data};

  wb_entry_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_a_i  (mem_push),
    .entry_a_i (mem_entry),
    .push_b_i  (alu_push),
    .entry_b_i (alu_entry),
    .pop_i     (rf_wr),
    .entries_o (entries),
    .head_o    (head),
    .count_o   (count)
  );

  assign head_entry = entries[head];
  assign rf_wr      = (count != '0) & ~wb_hold;
  assign rf_rd      = (count != '0) ? head_entry.rd : '0;
  assign rf_data    = (count != '0) ? head_entry.data : '0;

  // Walk oldest to youngest so the last match seen is the youngest value.
  always_comb begin
    rs_hit  = 1'b0;
    rs_data = '0;
    rt_hit  = 1'b0;
    rt_data = '0;
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[head + PtrW'(i)].valid) begin
        pending[entries[head + PtrW'(i)].rd] = 1'b1;
        if (entries[head + PtrW'(i)].rd == q_rs) begin
          rs_hit  = 1'b1;
          rs_data = entries[head + PtrW'(i)].data;
        end
        if (entries[head + PtrW'(i)].rd == q_rt) begin
          rt_hit  = 1'b1;
          rt_data = entries[head + PtrW'(i)].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench: per-scenario tasks plus a retire-order scoreboard.
module tb_reg_writeback_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid, wb_hold;
  logic [3:0]  mem_rd, alu_rd, q_rs, q_rt;
  logic [15:0] mem_data, alu_data;
  logic        mem_ready, alu_ready, rf_wr, rs_hit, rt_hit;
  logic [3:0]  rf_rd;
  logic [15:0] rf_data, rs_data, rt_data, pending;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  reg_writeback_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (16),
    .ADDR_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .wb_hold   (wb_hold),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .rf_wr     (rf_wr),
    .q_rs      (q_rs),
    .q_rt      (q_rt),
    .rs_hit    (rs_hit),
    .rs_data   (rs_data),
    .rt_hit    (rt_hit),
    .rt_data   (rt_data),
    .pending   (pending),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Scoreboard: model occupancy, push accepted results, pop on every expected retire.
  always @(negedge clk) begin
    int   n;
    logic exp_wr, exp_mr, exp_ar;
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      n      = sb.size();
      exp_wr = (n != 0) && !wb_hold;
      exp_mr = (n <= int'(DEPTH) - 1);
      exp_ar = (n <= int'(DEPTH) - 2) || ((n == int'(DEPTH) - 1) && !mem_valid);
      n_tests++;
      if (rf_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL sb_rf_wr: got %b expected %b (queued %0d)", rf_wr, exp_wr, n);
      end
      n_tests++;
      if (mem_ready !== exp_mr || alu_ready !== exp_ar) begin
        n_fail++;
        $display("FAIL sb_ready: got mem=%b alu=%b expected mem=%b alu=%b",
                 mem_ready, alu_ready, exp_mr, exp_ar);
      end
      if (exp_wr) begin
        e = sb.pop_front();
        n_tests++;
        if (rf_rd !== e.rd || rf_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_retire: got rd=%0d data=%h expected rd=%0d data=%h",
                   rf_rd, rf_data, e.rd, e.data);
        end
      end
      if (mem_valid && exp_mr) sb.push_back('{rd: mem_rd, data: mem_data});
      if (alu_valid && exp_ar) sb.push_back('{rd: alu_rd, data: alu_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (count !== 3'd0 || rf_wr !== 1'b0 || rf_rd !== 4'd0 || rf_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_retire: got count=%0d wr=%b rd=%0d data=%h expected 0 0 0 0",
               count, rf_wr, rf_rd, rf_data);
    end
    n_tests++;
    if (pending !== 16'd0 || rs_hit !== 1'b0 || rt_hit !== 1'b0 ||
        rs_data !== 16'd0 || rt_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_bypass: got pend=%h rs=%b/%h rt=%b/%h expected all 0",
               pending, rs_hit, rs_data, rt_hit, rt_data);
    end
    n_tests++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got mem=%b alu=%b expected 1 1", mem_ready, alu_ready);
    end
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1;
    alu_rd    = 4'd5;
    alu_data  = 16'h1234;
    tick();
    alu_valid = 1'b0;
    #1;
    n_tests++;
    if (rf_wr !== 1'b1 || rf_rd !== 4'd5 || rf_data !== 16'h1234 || pending !== 16'h0020) begin
      n_fail++;
      $display("FAIL single_alu_n1: got wr=%b rd=%0d data=%h pend=%h expected 1 5 1234 0020",
               rf_wr, rf_rd, rf_data, pending);
    end
    tick();
    n_tests++;
    if (pending !== 16'h0000 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_alu_n2: got pend=%h count=%0d expected 0000 0", pending, count);
    end
  endtask

  task automatic test_dual_same_reg();
    wb_hold   = 1'b1;
    mem_valid = 1'b1;
    mem_rd    = 4'd3;
    mem_data  = 16'hAAAA;
    alu_valid = 1'b1;
    alu_rd    = 4'd3;
    alu_data  = 16'h5555;
    tick();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    q_rs      = 4'd3;
    #1;
    n_tests++;
    if (count !== 3'd2 || rs_hit !== 1'b1 || rs_data !== 16'h5555 || pending !== 16'h0008) begin
      n_fail++;
      $display("FAIL dual_bypass: got count=%0d hit=%b data=%h pend=%h expected 2 1 5555 0008",
               count, rs_hit, rs_data, pending);
    end
    wb_hold = 1'b0;
    #1;
    n_tests++;
    if (rf_wr !== 1'b1 || rf_data !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL dual_first: got wr=%b data=%h expected 1 AAAA", rf_wr, rf_data);
    end
    tick();
    n_tests++;
    if (rf_wr !== 1'b1 || rf_data !== 16'h5555 || rs_data !== 16'h5555) begin
      n_fail++;
      $display("FAIL dual_second: got wr=%b data=%h byp=%h expected 1 5555 5555",
               rf_wr, rf_data, rs_data);
    end
    tick();
    n_tests++;
    if (count !== 3'd0 || rs_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_drain: got count=%0d hit=%b expected 0 0", count, rs_hit);
    end
  endtask

  task automatic test_full();
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1;
      mem_rd    = 4'(i + 1);
      mem_data  = 16'hF000 + 16'(i);
      tick();
    end
    mem_rd   = 4'd4;
    mem_data = 16'hF003;
    #1;
    n_tests++;
    if (count !== 3'd3 || mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_at3: got count=%0d mem=%b alu=%b expected 3 1 0",
               count, mem_ready, alu_ready);
    end
    tick();
    alu_valid = 1'b1;
    alu_rd    = 4'd6;
    alu_data  = 16'hBEEF;
    #1;
    n_tests++;
    if (count !== 3'd4 || mem_ready !== 1'b0 || alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_at4: got count=%0d mem=%b alu=%b expected 4 0 0",
               count, mem_ready, alu_ready);
    end
    tick();
    n_tests++;
    if (count !== 3'd4 || pending !== 16'h001E) begin
      n_fail++;
      $display("FAIL full_hold: got count=%0d pend=%h expected 4 001E", count, pending);
    end
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    wb_hold   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL full_drain: got count=%0d expected 0", count);
    end
  endtask

  task automatic test_reset_mid();
    wb_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 4'(i);
      alu_data  = 16'hC000 + 16'(i);
      tick();
    end
    alu_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst     = 1'b0;
    wb_hold = 1'b0;
    #1;
    n_tests++;
    if (count !== 3'd0 || rf_wr !== 1'b0 || pending !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got count=%0d wr=%b pend=%h expected 0 0 0000",
               count, rf_wr, pending);
    end
    tick();
    tick();
  endtask

  task automatic test_bypass_miss();
    q_rt = 4'd9;
    #1;
    n_tests++;
    if (rt_hit !== 1'b0 || rt_data !== 16'd0) begin
      n_fail++;
      $display("FAIL miss_empty: got hit=%b data=%h expected 0 0000", rt_hit, rt_data);
    end
    wb_hold   = 1'b1;
    mem_valid = 1'b1;
    mem_rd    = 4'd4;
    mem_data  = 16'h4444;
    tick();
    mem_valid = 1'b0;
    q_rs      = 4'd4;
    #1;
    n_tests++;
    if (rt_hit !== 1'b0 || rt_data !== 16'd0 || rs_hit !== 1'b1 || rs_data !== 16'h4444) begin
      n_fail++;
      $display("FAIL miss_other: got rt=%b/%h rs=%b/%h expected 0/0000 1/4444",
               rt_hit, rt_data, rs_hit, rs_data);
    end
    wb_hold = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int   acc   = 0;
    int   guard = 0;
    logic mv, av;
    wb_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 4'(7 + i);
      alu_data  = 16'hD000 + 16'(i);
      tick();
    end
    alu_rd   = 4'd9;
    alu_data = 16'hD002;
    wb_hold  = 1'b0;
    tick();
    alu_valid = 1'b0;
    #1;
    n_tests++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL b2b_steady: got count=%0d expected 2", count);
    end
    while (acc < 20 && guard < 200) begin
      if (!mem_valid && $urandom_range(0, 1) == 1) begin
        mem_valid = 1'b1;
        mem_rd    = 4'($urandom);
        mem_data  = 16'($urandom);
      end
      if (!alu_valid && $urandom_range(0, 1) == 1) begin
        alu_valid = 1'b1;
        alu_rd    = 4'($urandom);
        alu_data  = 16'($urandom);
      end
      wb_hold = ($urandom_range(0, 3) == 0);
      #1;
      mv = mem_valid && mem_ready;
      av = alu_valid && alu_ready;
      tick();
      if (mv) begin
        mem_valid = 1'b0;
        acc++;
      end
      if (av) begin
        alu_valid = 1'b0;
        acc++;
      end
      guard++;
    end
    n_tests++;
    if (acc < 20) begin
      n_fail++;
      $display("FAIL b2b_progress: got %0d accepted expected 20", acc);
    end
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    wb_hold   = 1'b0;
    guard     = 0;
    while (count != 3'd0 && guard < 20) begin
      tick();
      guard++;
    end
    #1;
    n_tests++;
    if (count !== 3'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got count=%0d left=%0d expected 0 0", count, sb.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    wb_hold   = 1'b0;
    mem_rd    = '0;
    alu_rd    = '0;
    mem_data  = '0;
    alu_data  = '0;
    q_rs      = '0;
    q_rt      = '0;
    test_reset();
    test_single_alu();
    test_dual_same_reg();
    test_full();
    test_reset_mid();
    test_bypass_miss();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
